// File: rtl/frogger_game_seq.sv
// Frogger game-flow sequencer: start, play, death, level-clear and game-over phases.
// Optional build macro FROGGER_BONUS_LIFE_EN: clearing a level awards one life (saturating at 7).
module frogger_game_seq #(
  parameter int unsigned LIVES         = 3,
  parameter int unsigned TICKS_PER_SEC = 60,
  parameter int unsigned ROUND_SECS    = 30,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned LEVEL_FRAMES  = 90,
  parameter int unsigned NUM_PADS      = 5
) (
  input  logic                i_Clk,
  input  logic                i_Rst_N,
  input  logic                i_Start,
  input  logic                i_Frame_Tick,
  input  logic                i_Collided,
  input  logic                i_Frog_Home,
  input  logic [2:0]          i_Home_Slot,
  output logic                o_Game_Active,
  output logic                o_Frog_Reset,
  output logic                o_Dying,
  output logic                o_Game_Over,
  output logic [2:0]          o_Lives,
  output logic [2:0]          o_Level,
  output logic [5:0]          o_Time_Left,
  output logic [NUM_PADS-1:0] o_Pads_Filled,
  output logic [2:0]          o_State
);

  localparam int unsigned SUB_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned PH_MAX = (DEATH_FRAMES > LEVEL_FRAMES) ? DEATH_FRAMES : LEVEL_FRAMES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAYING   = 3'd1,
    S_DYING     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_start_q;
  logic [SUB_W-1:0]    r_sub, w_sub_nxt;
  logic [PH_W-1:0]     r_phase, w_phase_nxt;
  logic [2:0]          r_lives, w_lives_nxt;
  logic [2:0]          r_level, w_level_nxt;
  logic [5:0]          r_time, w_time_nxt;
  logic [NUM_PADS-1:0] r_pads, w_pads_nxt;
  logic                r_frog_reset, w_frog_reset_nxt;
  logic                r_game_active, r_dying, r_game_over;
  logic                w_start_rise, w_slot_ok, w_enter_dying, w_respawn;
  logic [NUM_PADS-1:0] w_slot_mask;

  assign w_start_rise = i_Start & ~r_start_q;
  assign w_slot_ok    = (32'(i_Home_Slot) < NUM_PADS);
  assign w_slot_mask  = NUM_PADS'(1) << i_Home_Slot;

  // State and datapath registers
  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      r_state       <= S_IDLE;
      r_start_q     <= 1'b0;
      r_sub         <= '0;
      r_phase       <= '0;
      r_lives       <= 3'(LIVES);
      r_level       <= 3'd1;
      r_time        <= 6'(ROUND_SECS);
      r_pads        <= '0;
      r_frog_reset  <= 1'b0;
      r_game_active <= 1'b0;
      r_dying       <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_q     <= i_Start;
      r_sub         <= w_sub_nxt;
      r_phase       <= w_phase_nxt;
      r_lives       <= w_lives_nxt;
      r_level       <= w_level_nxt;
      r_time        <= w_time_nxt;
      r_pads        <= w_pads_nxt;
      r_frog_reset  <= w_frog_reset_nxt;
      r_game_active <= (w_state_nxt == S_PLAYING);
      r_dying       <= (w_state_nxt == S_DYING);
      r_game_over   <= (w_state_nxt == S_GAME_OVER);
    end
  end

  // Next-state logic; dying entry and respawn are shared tails applied after the case
  always_comb begin
    w_state_nxt      = r_state;
    w_sub_nxt        = r_sub;
    w_phase_nxt      = r_phase;
    w_lives_nxt      = r_lives;
    w_level_nxt      = r_level;
    w_time_nxt       = r_time;
    w_pads_nxt       = r_pads;
    w_frog_reset_nxt = 1'b0;
    w_enter_dying    = 1'b0;
    w_respawn        = 1'b0;

    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (w_start_rise) begin
          w_lives_nxt = 3'(LIVES);
          w_level_nxt = 3'd1;
          w_pads_nxt  = '0;
          w_respawn   = 1'b1;
        end
      end
      S_PLAYING: begin
        if (i_Collided) begin
          w_enter_dying = 1'b1;
        end else if (i_Frog_Home) begin
          if (w_slot_ok && ((r_pads & w_slot_mask) == '0)) begin
            w_pads_nxt = r_pads | w_slot_mask;
            w_time_nxt = 6'(ROUND_SECS);
            w_sub_nxt  = '0;
            if (w_pads_nxt == {NUM_PADS{1'b1}}) begin
              w_state_nxt = S_LEVEL_UP;
              w_phase_nxt = '0;
            end else begin
              w_frog_reset_nxt = 1'b1;
            end
          end else begin
            w_enter_dying = 1'b1;
          end
        end else if (i_Frame_Tick) begin
          if (r_sub == SUB_W'(TICKS_PER_SEC - 1)) begin
            w_sub_nxt  = '0;
            w_time_nxt = r_time - 6'd1;
            if (r_time == 6'd1) w_enter_dying = 1'b1;
          end else begin
            w_sub_nxt = r_sub + SUB_W'(1);
          end
        end
      end
      S_DYING: begin
        if (i_Frame_Tick) begin
          if (r_phase == PH_W'(DEATH_FRAMES - 1)) begin
            if (r_lives == 3'd0) w_state_nxt = S_GAME_OVER;
            else                 w_respawn   = 1'b1;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
      end
      S_LEVEL_UP: begin
        if (i_Frame_Tick) begin
          if (r_phase == PH_W'(LEVEL_FRAMES - 1)) begin
            w_pads_nxt  = '0;
            w_level_nxt = (r_level == 3'd7) ? 3'd7 : r_level + 3'd1;
`ifdef FROGGER_BONUS_LIFE_EN
            w_lives_nxt = (r_lives == 3'd7) ? 3'd7 : r_lives + 3'd1;
`else
            w_lives_nxt = r_lives;
`endif
            w_respawn   = 1'b1;
          end else begin
            w_phase_nxt = r_phase + PH_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_enter_dying) begin
      w_state_nxt = S_DYING;
      w_phase_nxt = '0;
      w_lives_nxt = (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
    end
    if (w_respawn) begin
      w_state_nxt      = S_PLAYING;
      w_time_nxt       = 6'(ROUND_SECS);
      w_sub_nxt        = '0;
      w_frog_reset_nxt = 1'b1;
    end
  end

  assign o_State       = r_state;
  assign o_Game_Active = r_game_active;
  assign o_Dying       = r_dying;
  assign o_Game_Over   = r_game_over;
  assign o_Frog_Reset  = r_frog_reset;
  assign o_Lives       = r_lives;
  assign o_Level       = r_level;
  assign o_Time_Left   = r_time;
  assign o_Pads_Filled = r_pads;

endmodule

// File: tb/tb_frogger_game_seq.sv
// Scoreboard bench for frogger_game_seq: stimulus queues expected snapshots, monitors compare.
module tb_frogger_game_seq;

  localparam int X = -1;
`ifdef FROGGER_BONUS_LIFE_EN
  localparam int BON = 1;
`else
  localparam int BON = 0;
`endif
  localparam int L = 3 + BON;

  typedef struct {
    string nm;
    int st, fr, lv, lvl, tl, pads;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start = 1'b0, tick = 1'b0, col = 1'b0, home = 1'b0;
  logic [2:0] slot = 3'd0;

  logic       o_Game_Active, o_Frog_Reset, o_Dying, o_Game_Over;
  logic [2:0] o_Lives, o_Level, o_State;
  logic [5:0] o_Time_Left;
  logic [4:0] o_Pads_Filled;

  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  exp_t rq[$];

  always #5 clk = ~clk;

  frogger_game_seq #(
    .LIVES(3), .TICKS_PER_SEC(2), .ROUND_SECS(3),
    .DEATH_FRAMES(4), .LEVEL_FRAMES(4), .NUM_PADS(5)
  ) dut (
    .i_Clk(clk), .i_Rst_N(rst_n), .i_Start(start), .i_Frame_Tick(tick),
    .i_Collided(col), .i_Frog_Home(home), .i_Home_Slot(slot),
    .o_Game_Active(o_Game_Active), .o_Frog_Reset(o_Frog_Reset), .o_Dying(o_Dying),
    .o_Game_Over(o_Game_Over), .o_Lives(o_Lives), .o_Level(o_Level),
    .o_Time_Left(o_Time_Left), .o_Pads_Filled(o_Pads_Filled), .o_State(o_State)
  );

  function automatic exp_t E(input string nm, input int st, input int fr, input int lv,
                             input int lvl, input int tl, input int pads);
    exp_t e;
    e.nm = nm; e.st = st; e.fr = fr; e.lv = lv; e.lvl = lvl; e.tl = tl; e.pads = pads;
    return e;
  endfunction

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, fld, act, exp, $time);
    end
  endtask

  task automatic compare(input exp_t e);
    if (e.st >= 0) begin
      chk(e.nm, "state", int'(o_State), e.st);
      chk(e.nm, "game_active", int'(o_Game_Active), (e.st == 1) ? 1 : 0);
      chk(e.nm, "dying", int'(o_Dying), (e.st == 2) ? 1 : 0);
      chk(e.nm, "game_over", int'(o_Game_Over), (e.st == 4) ? 1 : 0);
    end
    if (e.fr >= 0)   chk(e.nm, "frog_reset", int'(o_Frog_Reset), e.fr);
    if (e.lv >= 0)   chk(e.nm, "lives", int'(o_Lives), e.lv);
    if (e.lvl >= 0)  chk(e.nm, "level", int'(o_Level), e.lvl);
    if (e.tl >= 0)   chk(e.nm, "time_left", int'(o_Time_Left), e.tl);
    if (e.pads >= 0) chk(e.nm, "pads", int'(o_Pads_Filled), e.pads);
  endtask

  // Synchronous monitor: one expected snapshot per clocked cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) compare(q.pop_front());
    end
  end

  // Asynchronous-reset monitor: checks outputs before any clock edge follows
  initial begin
    forever begin
      @(negedge rst_n);
      #1;
      if (rq.size() > 0) compare(rq.pop_front());
    end
  end

  task automatic cyc(input logic st, input logic tk, input logic c, input logic h,
                     input logic [2:0] s, input exp_t e);
    @(negedge clk);
    start = st; tick = tk; col = c; home = h; slot = s;
    q.push_back(e);
  endtask

  task automatic ticks(input int n, input exp_t mid, input exp_t last);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, (i == n - 1) ? last : mid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cyc(0, 0, 0, 0, 0, E("reset", 0, 0, 3, 1, 3, 0));
    cyc(1, 0, 0, 0, 0, E("newgame", 1, 1, 3, 1, 3, 0));
    cyc(0, 0, 0, 0, 0, E("newgame_pulse_end", 1, 0, 3, 1, 3, 0));
    cyc(1, 0, 0, 0, 0, E("start_ign_play", 1, 0, 3, 1, 3, 0));

    // Fill all five pads
    for (int s = 0; s < 5; s++) begin
      int m;
      m = (1 << (s + 1)) - 1;
      if (s < 4) begin
        cyc(0, 0, 0, 1, 3'(s), E("pad_fill", 1, 1, 3, 1, 3, m));
        cyc(0, 0, 0, 0, 0, E("pad_idle", 1, 0, 3, 1, 3, m));
      end else begin
        cyc(0, 0, 0, 1, 3'(s), E("pads_full", 3, 0, 3, 1, 3, 31));
      end
    end
    ticks(4, E("levelup_wait", 3, 0, 3, 1, 3, 31), E("levelup_exit", 1, 1, L, 2, 3, 0));
    cyc(0, 0, 0, 0, 0, E("level2_idle", 1, 0, L, 2, 3, 0));

    // Repeated home on an occupied pad
    cyc(0, 0, 0, 1, 3'd1, E("pad1_fill", 1, 1, L, 2, 3, 2));
    cyc(0, 0, 0, 0, 0, E("pad1_idle", 1, 0, L, 2, 3, 2));
    cyc(0, 0, 0, 1, 3'd1, E("pad1_repeat", 2, 0, L - 1, 2, 3, 2));
    ticks(4, E("dying_wait", 2, 0, L - 1, 2, 3, 2), E("respawn1", 1, 1, L - 1, 2, 3, 2));
    cyc(0, 0, 0, 0, 0, E("respawn1_idle", 1, 0, L - 1, 2, 3, 2));

    // Time-out: six ticks at two ticks per second from three seconds
    cyc(0, 1, 0, 0, 0, E("tmr1", 1, 0, L - 1, 2, 3, 2));
    cyc(0, 1, 0, 0, 0, E("tmr2", 1, 0, L - 1, 2, 2, 2));
    cyc(0, 1, 0, 0, 0, E("tmr3", 1, 0, L - 1, 2, 2, 2));
    cyc(0, 1, 0, 0, 0, E("tmr4", 1, 0, L - 1, 2, 1, 2));
    cyc(0, 1, 0, 0, 0, E("tmr5", 1, 0, L - 1, 2, 1, 2));
    cyc(0, 1, 0, 0, 0, E("timeout", 2, 0, L - 2, 2, 0, 2));
    ticks(4, E("to_dying", 2, 0, L - 2, 2, 0, 2), E("respawn2", 1, 1, L - 2, 2, 3, 2));
    cyc(0, 0, 0, 0, 0, E("respawn2_idle", 1, 0, L - 2, 2, 3, 2));

    // Collision beats home in the same cycle
    cyc(0, 0, 1, 1, 3'd2, E("col_vs_home", 2, 0, L - 3, 2, 3, 2));
    ticks(2, E("dying_mid", 2, 0, L - 3, 2, 3, 2), E("dying_mid", 2, 0, L - 3, 2, 3, 2));

    // Asynchronous reset mid-count
    @(negedge clk);
    tick = 1'b0;
    #1;
    rq.push_back(E("async_reset", 0, 0, 3, 1, 3, 0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ticks(3, E("post_reset_tick", 0, 0, 3, 1, 3, 0), E("post_reset_tick", 0, 0, 3, 1, 3, 0));

    // Fresh game, three deaths to game over
    cyc(1, 0, 0, 0, 0, E("newgame2", 1, 1, 3, 1, 3, 0));
    cyc(0, 0, 0, 0, 0, E("newgame2_idle", 1, 0, 3, 1, 3, 0));
    cyc(0, 0, 1, 1, 3'd2, E("death1", 2, 0, 2, 1, 3, 0));
    ticks(4, E("d1_wait", 2, 0, 2, 1, 3, 0), E("d1_respawn", 1, 1, 2, 1, 3, 0));
    cyc(0, 0, 1, 0, 0, E("death2", 2, 0, 1, 1, 3, 0));
    ticks(4, E("d2_wait", 2, 0, 1, 1, 3, 0), E("d2_respawn", 1, 1, 1, 1, 3, 0));
    cyc(0, 0, 1, 0, 0, E("death3", 2, 0, 0, 1, 3, 0));
    ticks(4, E("d3_wait", 2, 0, 0, 1, 3, 0), E("game_over", 4, 0, 0, 1, 3, 0));
    cyc(0, 1, 1, 1, 3'd0, E("game_over_hold", 4, 0, 0, 1, 3, 0));
    cyc(1, 0, 0, 0, 0, E("restart", 1, 1, 3, 1, 3, 0));
    cyc(0, 0, 0, 0, 0, E("restart_idle", 1, 0, 3, 1, 3, 0));

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
